// File: rtl/cpu_pkg.sv
// Shared CPU constants: default widths, opcodes and fetch-state encoding.
`timescale 1ns/1ps
package cpu_pkg;

    localparam int CPU_PC_W = 8;
    localparam int CPU_IW   = 16;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_LOAD  = 4'h1;
    localparam logic [3:0] OPC_ADD   = 4'h2;
    localparam logic [3:0] OPC_SUB   = 4'h3;
    localparam logic [3:0] OPC_AND   = 4'h4;
    localparam logic [3:0] OPC_OR    = 4'h5;
    localparam logic [3:0] OPC_STORE = 4'h8;
    localparam logic [3:0] OPC_JMP   = 4'h9;
    localparam logic [3:0] OPC_JZ    = 4'hA;
    localparam logic [3:0] OPC_HALT  = 4'hC;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_HALT
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Non-prefetching instruction fetch unit driving a synchronous PROGRAM_RAM.
// Define INSTR_FETCH_HALT_EN to stop fetching after an OPC_HALT is consumed.
`timescale 1ns/1ps
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int PC_W     = CPU_PC_W,
    parameter int IW       = CPU_IW,
    parameter int READ_LAT = 1
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_addr,
    output logic [PC_W-1:0] ram_addr,
    output logic            ram_rden,
    input  logic [IW-1:0]   ram_q,
    output logic [IW-1:0]   ir,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_addr;
    logic            r_rden;
    logic [IW-1:0]   r_ir;
    logic            r_ir_valid;
    logic [1:0]      r_wcnt;

    logic            w_active;
    logic            w_jmp;
    logic            w_hs;
    logic            w_last;
    logic            w_halt_hit;
    logic [PC_W-1:0] w_pc_inc;

    assign w_active = (r_state == FS_REQ) || (r_state == FS_WAIT) ||
                      (r_state == FS_HOLD);
    assign w_jmp    = jmp_en && w_active;
    assign w_hs     = (r_state == FS_HOLD) && r_ir_valid && ir_ready;
    assign w_last   = (r_wcnt == 2'(READ_LAT - 1));
    assign w_pc_inc = r_pc + PC_W'(1);

`ifdef INSTR_FETCH_HALT_EN
    assign w_halt_hit = (r_ir[IW-1 -: 4] == OPC_HALT);
    assign halted     = (r_state == FS_HALT);
`else
    assign w_halt_hit = 1'b0;
    assign halted     = 1'b0;
`endif

    // rden is a registered one-cycle pulse raised on every entry into REQ
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state    <= FS_IDLE;
            r_pc       <= '0;
            r_addr     <= '0;
            r_rden     <= 1'b0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_wcnt     <= '0;
        end else begin
            r_rden <= 1'b0;
            if (w_jmp) begin
                r_pc       <= jmp_addr;
                r_addr     <= jmp_addr;
                r_rden     <= 1'b1;
                r_ir_valid <= 1'b0;
                r_state    <= FS_REQ;
            end else begin
                unique case (r_state)
                    FS_IDLE: begin
                        if (start) begin
                            r_pc    <= start_addr;
                            r_addr  <= start_addr;
                            r_rden  <= 1'b1;
                            r_state <= FS_REQ;
                        end
                    end
                    FS_REQ: begin
                        r_wcnt  <= '0;
                        r_state <= FS_WAIT;
                    end
                    FS_WAIT: begin
                        if (w_last) begin
                            r_ir       <= ram_q;
                            r_ir_valid <= 1'b1;
                            r_state    <= FS_HOLD;
                        end else begin
                            r_wcnt <= r_wcnt + 2'd1;
                        end
                    end
                    FS_HOLD: begin
                        if (w_hs && w_halt_hit) begin
                            r_ir_valid <= 1'b0;
                            r_state    <= FS_HALT;
                        end else if (w_hs) begin
                            r_ir_valid <= 1'b0;
                            r_pc       <= w_pc_inc;
                            r_addr     <= w_pc_inc;
                            r_rden     <= 1'b1;
                            r_state    <= FS_REQ;
                        end
                    end
                    FS_HALT: begin
                        if (start) begin
                            r_pc    <= start_addr;
                            r_addr  <= start_addr;
                            r_rden  <= 1'b1;
                            r_state <= FS_REQ;
                        end
                    end
                    default: r_state <= FS_IDLE;
                endcase
            end
        end
    end

    assign ram_addr = r_addr;
    assign ram_rden = r_rden;
    assign ir       = r_ir;
    assign ir_valid = r_ir_valid;
    assign pc       = r_pc;

endmodule
